generador_obstaculos: RTL and testbench

Obstacle and bonus generator for the three-digit obstacle field. Each `clk_obstaculos` rising edge scrolls 7-segment obstacle patterns from display 2 toward the hero display (display 0), injecting LFSR-chosen obstacles, blank gaps and periodic bonus patterns. It produces `display_obs` and `mundo`, which the collision checker samples on the falling edge. It consumes that checker's `bono_tomado` and `W_or_L` results.

---
 rtl/generador_obstaculos_if.sv | 25 ++
 rtl/generador_obstaculos.sv | 139 +++++++++++++
 tb/tb_generador_obstaculos.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/generador_obstaculos_if.sv
// Game-side bundle for the obstacle generator: game state and collision results in,
// the three-display obstacle field and the world counter out.
interface generador_obstaculos_if;
  logic [2:0]  presente;
  logic        bono_tomado;
  logic [1:0]  W_or_L;
  logic [20:0] display_obs;
  logic [1:0]  mundo;

  modport master (
    output presente,
    output bono_tomado,
    output W_or_L,
    input  display_obs,
    input  mundo
  );

  modport slave (
    input  presente,
    input  bono_tomado,
    input  W_or_L,
    output display_obs,
    output mundo
  );
endinterface

// File: rtl/generador_obstaculos.sv
// Obstacle/bonus generator: scrolls 7-segment patterns from display 2 toward the
// hero display, inserting LFSR obstacles, blank gaps and periodic bonuses.
module generador_obstaculos #(
  parameter int         OBS_POR_MUNDO = 8,
  parameter int         BONO_CADA     = 5,
  parameter int         GAP           = 1,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input logic                   clk_obstaculos,
  input logic                   rst,
  generador_obstaculos_if.slave bus
);
  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] WLCM = 3'd1;
  localparam logic [2:0] CH   = 3'd2;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  localparam logic [6:0] BONO   = 7'h7F;
  localparam logic [6:0] VACIO  = 7'h00;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_FIN} state_t;

  state_t      state_reg, state_next;
  logic [20:0] display_reg, display_next;
  logic [1:0]  mundo_reg, mundo_next;
  logic [7:0]  pasados_reg, pasados_next;
  logic [7:0]  lfsr_reg, lfsr_next;
  logic [3:0]  ins_reg, ins_next;
  logic [2:0]  hueco_reg, hueco_next;
  logic [6:0]  nuevo;
  logic [6:0]  saliente;

  function automatic logic [6:0] patron(input logic [2:0] idx);
    case (idx)
      3'd0:    return 7'h40;
      3'd1:    return 7'h01;
      3'd2:    return 7'h08;
      3'd3:    return 7'h41;
      3'd4:    return 7'h09;
      3'd5:    return 7'h48;
      3'd6:    return 7'h02;
      default: return 7'h10;
    endcase
  endfunction

  always_ff @(posedge clk_obstaculos or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      display_reg <= '0;
      mundo_reg   <= '0;
      pasados_reg <= '0;
      lfsr_reg    <= SEED;
      ins_reg     <= '0;
      hueco_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      display_reg <= display_next;
      mundo_reg   <= mundo_next;
      pasados_reg <= pasados_next;
      lfsr_reg    <= lfsr_next;
      ins_reg     <= ins_next;
      hueco_reg   <= hueco_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    display_next = display_reg;
    mundo_next   = mundo_reg;
    pasados_next = pasados_reg;
    lfsr_next    = lfsr_reg;
    ins_next     = ins_reg;
    hueco_next   = hueco_reg;
    nuevo        = VACIO;
    saliente     = display_reg[6:0];

    // A finished game stays finished until the game leaves the playing states.
    case (bus.presente)
      OFF, WLCM, CH: state_next = S_IDLE;
      GAME: begin
        if (state_reg == S_FIN || mundo_reg == 2'd3) state_next = S_FIN;
        else if (bus.W_or_L != 2'b00)                 state_next = S_HOLD;
        else                                          state_next = S_RUN;
      end
      WL, PA: begin
        if (state_reg == S_FIN || mundo_reg == 2'd3) state_next = S_FIN;
        else                                          state_next = S_HOLD;
      end
      default: state_next = S_IDLE;
    endcase

    case (state_next)
      S_IDLE: begin
        display_next = '0;
        mundo_next   = '0;
        pasados_next = '0;
        lfsr_next    = SEED;
        ins_next     = '0;
        hueco_next   = '0;
      end
      S_RUN: begin
        // The edge that enters S_RUN only arms scrolling; shifting starts next edge.
        if (state_reg == S_RUN) begin
          if (hueco_reg != 3'd0) begin
            hueco_next = hueco_reg - 3'd1;
          end else if (ins_reg == 4'(BONO_CADA - 1)) begin
            nuevo      = BONO;
            ins_next   = '0;
            hueco_next = 3'(GAP);
          end else begin
            nuevo      = patron(lfsr_reg[2:0]);
            ins_next   = ins_reg + 4'd1;
            hueco_next = 3'(GAP);
            lfsr_next  = {lfsr_reg[6:0],
                          lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
          end
          display_next = {nuevo, display_reg[20:7]};
          if (saliente != VACIO && saliente != BONO) begin
            if (pasados_reg == 8'(OBS_POR_MUNDO - 1)) begin
              pasados_next = '0;
              if (mundo_reg != 2'd3) mundo_next = mundo_reg + 2'd1;
            end else begin
              pasados_next = pasados_reg + 8'd1;
            end
          end
        end
      end
      S_HOLD: begin
        if (bus.bono_tomado && display_reg[6:0] == BONO) display_next[6:0] = VACIO;
      end
      default: ;
    endcase
  end

  assign bus.display_obs = display_reg;
  assign bus.mundo       = mundo_reg;
endmodule

// File: tb/tb_generador_obstaculos.sv
// Directed bench for generador_obstaculos with a slot-based reference model feeding
// an expected-value scoreboard that is drained after every scroll-clock edge.
module tb_generador_obstaculos;
  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  logic clk;
  logic rst;

  generador_obstaculos_if bus_if();

  generador_obstaculos dut (
    .clk_obstaculos (clk),
    .rst            (rst),
    .bus            (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [6:0]  pat [8];
  logic [6:0]  m_slot [3];
  logic [7:0]  m_lfsr;
  int          m_state;   // 0 idle, 1 run, 2 hold, 3 fin
  int          m_mundo, m_pasados, m_ins, m_hueco;
  int          n_insert, n_exit;
  logic [20:0] sb_disp [$];
  logic [1:0]  sb_mundo [$];
  logic [20:0] frozen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $display("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic model_clear();
    m_slot[0] = '0; m_slot[1] = '0; m_slot[2] = '0;
    m_lfsr = 8'hA5;
    m_mundo = 0; m_pasados = 0; m_ins = 0; m_hueco = 0;
    n_insert = 0; n_exit = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_state = 0;
  endtask

  function automatic logic [20:0] model_disp();
    return {m_slot[2], m_slot[1], m_slot[0]};
  endfunction

  task automatic model_edge();
    int nxt;
    logic [6:0] ent;
    logic [6:0] sal;
    logic [2:0] p;
    p = bus_if.presente;
    if (!(p == GAME || p == PA || p == WL)) nxt = 0;
    else if (m_state == 3 || m_mundo == 3) nxt = 3;
    else if (bus_if.W_or_L != 2'b00 || p != GAME) nxt = 2;
    else nxt = 1;

    if (nxt == 0) begin
      model_clear();
    end else if (nxt == 1 && m_state == 1) begin
      if (m_hueco > 0) begin
        ent = 7'h00;
        m_hueco--;
      end else if (m_ins == 4) begin
        ent = 7'h7F;
        m_ins = 0;
        m_hueco = 1;
        n_insert++;
      end else begin
        ent = pat[m_lfsr[2:0]];
        m_ins++;
        m_hueco = 1;
        m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
        n_insert++;
      end
      sal = m_slot[0];
      m_slot[0] = m_slot[1];
      m_slot[1] = m_slot[2];
      m_slot[2] = ent;
      if (sal != 7'h00 && sal != 7'h7F) begin
        n_exit++;
        m_pasados++;
        if (m_pasados == 8) begin
          m_pasados = 0;
          if (m_mundo < 3) m_mundo++;
        end
      end
    end else if (nxt == 2 && bus_if.bono_tomado && m_slot[0] == 7'h7F) begin
      m_slot[0] = 7'h00;
    end
    m_state = nxt;
    sb_disp.push_back(model_disp());
    sb_mundo.push_back(2'(m_mundo));
  endtask

  task automatic step();
    logic [20:0] ed;
    logic [1:0]  em;
    model_edge();
    @(posedge clk);
    #1;
    ed = sb_disp.pop_front();
    em = sb_mundo.pop_front();
    chk("sb_display", bus_if.display_obs, ed);
    chk("sb_mundo", bus_if.mundo, em);
  endtask

  initial begin
    pat = '{7'h40, 7'h01, 7'h08, 7'h41, 7'h09, 7'h48, 7'h02, 7'h10};
    rst = 1'b1;
    bus_if.presente    = OFF;
    bus_if.bono_tomado = 1'b0;
    bus_if.W_or_L      = 2'b00;
    model_reset();
    #12;
    rst = 1'b0;
    chk("reset_display", bus_if.display_obs, 21'h0);
    chk("reset_mundo", bus_if.mundo, 2'd0);
    $display("txn reset released");

    step();
    step();
    bus_if.presente = GAME;
    step();
    $display("txn edge1 display=%h", bus_if.display_obs);
    chk("arranque_sin_shift", bus_if.display_obs, 21'h0);
    step();
    $display("txn edge2 display=%h", bus_if.display_obs);
    chk("esc1_edge2", bus_if.display_obs, 21'h120000);
    step();
    $display("txn edge3 display=%h", bus_if.display_obs);
    chk("esc1_edge3", bus_if.display_obs, 21'h002400);
    step();
    $display("txn edge4 display=%h", bus_if.display_obs);
    chk("esc1_edge4", bus_if.display_obs, 21'h020048);

    for (int i = 0; i < 40 && n_insert < 5; i++) step();
    if (n_insert < 5) timeout("insercion5");
    $display("txn insertion5 display=%h", bus_if.display_obs);
    chk("bono_insercion5", bus_if.display_obs[20:14], 7'h7F);

    frozen = model_disp();
    bus_if.presente = PA;
    for (int i = 0; i < 5; i++) begin
      step();
      $display("txn pausa display=%h", bus_if.display_obs);
      chk("pausa_congelada", bus_if.display_obs, frozen);
    end
    bus_if.presente = GAME;
    step();
    chk("reanuda_sin_salto", bus_if.display_obs, frozen);
    step();
    $display("txn reanuda display=%h", bus_if.display_obs);
    chk("reanuda_shift", bus_if.display_obs[13:0], frozen[20:7]);

    for (int i = 0; i < 40 && m_slot[0] != 7'h7F; i++) step();
    if (m_slot[0] != 7'h7F) timeout("bono_en_d0");
    chk("bono_en_d0", bus_if.display_obs[6:0], 7'h7F);
    frozen = model_disp();
    bus_if.W_or_L      = 2'b01;
    bus_if.bono_tomado = 1'b1;
    step();
    $display("txn perdio_con_bono display=%h", bus_if.display_obs);
    chk("hold_d0_limpio", bus_if.display_obs[6:0], 7'h00);
    chk("hold_d2_d1", bus_if.display_obs[20:7], frozen[20:7]);
    for (int i = 0; i < 3; i++) step();
    bus_if.W_or_L      = 2'b00;
    bus_if.bono_tomado = 1'b0;
    for (int i = 0; i < 6; i++) step();

    #2;
    rst = 1'b1;
    #1;
    model_reset();
    $display("txn rst_pulse display=%h mundo=%0d", bus_if.display_obs, bus_if.mundo);
    chk("rst_async_display", bus_if.display_obs, 21'h0);
    chk("rst_async_mundo", bus_if.mundo, 2'd0);
    #1;
    rst = 1'b0;
    step();
    step();
    $display("txn replay edge2 display=%h", bus_if.display_obs);
    chk("replay_edge2", bus_if.display_obs, 21'h120000);

    for (int i = 0; i < 200 && n_exit < 8; i++) step();
    if (n_exit < 8) timeout("salida8");
    $display("txn exit8 mundo=%0d", bus_if.mundo);
    chk("mundo_salida8", bus_if.mundo, 2'd1);
    for (int i = 0; i < 200 && n_exit < 16; i++) step();
    if (n_exit < 16) timeout("salida16");
    $display("txn exit16 mundo=%0d", bus_if.mundo);
    chk("mundo_salida16", bus_if.mundo, 2'd2);
    for (int i = 0; i < 200 && n_exit < 24; i++) step();
    if (n_exit < 24) timeout("salida24");
    $display("txn exit24 mundo=%0d", bus_if.mundo);
    chk("mundo_salida24", bus_if.mundo, 2'd3);

    frozen = model_disp();
    for (int i = 0; i < 11; i++) begin
      step();
      $display("txn fin display=%h mundo=%0d", bus_if.display_obs, bus_if.mundo);
      chk("fin_congelado", bus_if.display_obs, frozen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
